// File: rtl/lut_neuron_pkg.sv
// Shared definitions for the LUT neuron layer.
// Contents: default parameter values, config neuron-index width function,
// and bit-offset helpers for the packed per-neuron address and result buses.
// Optional build macro used by the layer: LUT_NEURON_READBACK_EN.
package lut_neuron_pkg;

  localparam int unsigned DEF_IN_BITS     = 8;
  localparam int unsigned DEF_OUT_BITS    = 1;
  localparam int unsigned DEF_NUM_NEURONS = 4;

  // Index width for addressing num neurons; never narrower than 1 bit.
  function automatic int unsigned neur_idx_w(input int unsigned num);
    return (num > 1) ? int'($clog2(num)) : 1;
  endfunction

  // LSB of neuron n's address field within the packed input bus.
  function automatic int unsigned addr_lsb(input int unsigned n, input int unsigned in_bits);
    return n * in_bits;
  endfunction

  // LSB of neuron n's result field within the packed output bus.
  function automatic int unsigned out_lsb(input int unsigned n, input int unsigned out_bits);
    return n * out_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron's truth table: 2**IN_BITS x OUT_BITS RAM, no reset.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata asynchronous
// lookup read. With LUT_NEURON_READBACK_EN: cfg_raddr/cfg_rdata, a second
// asynchronous read port for configuration readback.
module lut_neuron_table
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_BITS  = DEF_IN_BITS,
  parameter int unsigned OUT_BITS = DEF_OUT_BITS
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IN_BITS-1:0]  waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [IN_BITS-1:0]  raddr,
  output logic [OUT_BITS-1:0] rdata
`ifdef LUT_NEURON_READBACK_EN
  ,
  input  logic [IN_BITS-1:0]  cfg_raddr,
  output logic [OUT_BITS-1:0] cfg_rdata
`endif
);

  localparam int unsigned DEPTH = 1 << IN_BITS;

  logic [OUT_BITS-1:0] mem_q [DEPTH];

  // Write at the edge; reads see the pre-edge contents (read-before-write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

`ifdef LUT_NEURON_READBACK_EN
  assign cfg_rdata = mem_q[cfg_raddr];
`endif

endmodule

// File: rtl/lut_neuron_layer_pipe.sv
// Layer of NUM_NEURONS programmable truth-table neurons behind a 2-stage
// elastic valid/ready pipeline (S1 holds addresses, S2 holds results).
// Ports: clk, rst (sync, active high); in_data/in_valid/in_ready upstream;
// out_data/out_valid/out_ready downstream; cfg_we/cfg_neuron/cfg_addr/
// cfg_wdata table write port. Macro LUT_NEURON_READBACK_EN adds cfg_re,
// cfg_rvalid, cfg_rdata for registered table readback.
module lut_neuron_layer_pipe
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_BITS     = DEF_IN_BITS,
  parameter int unsigned OUT_BITS    = DEF_OUT_BITS,
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned NEUR_IDX_W  = neur_idx_w(NUM_NEURONS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            cfg_we,
  input  logic [NEUR_IDX_W-1:0]           cfg_neuron,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_wdata
`ifdef LUT_NEURON_READBACK_EN
  ,
  input  logic                            cfg_re,
  output logic                            cfg_rvalid,
  output logic [OUT_BITS-1:0]             cfg_rdata
`endif
);

  localparam int unsigned AW = NUM_NEURONS * IN_BITS;
  localparam int unsigned DW = NUM_NEURONS * OUT_BITS;

  logic          s1_valid_q, s1_valid_d;
  logic [AW-1:0] s1_addr_q,  s1_addr_d;
  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] s2_data_q,  s2_data_d;
  logic [DW-1:0] lookup_data;
  logic          s2_ready;

  assign s2_ready  = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_ready;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;

  // Per-neuron tables; an out-of-range cfg_neuron matches no instance.
`ifdef LUT_NEURON_READBACK_EN
  logic [DW-1:0] cfg_rd_all;
`endif
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    lut_neuron_table #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_table (
      .clk      (clk),
      .we       (cfg_we && (cfg_neuron == NEUR_IDX_W'(n))),
      .waddr    (cfg_addr),
      .wdata    (cfg_wdata),
      .raddr    (s1_addr_q[addr_lsb(n, IN_BITS) +: IN_BITS]),
      .rdata    (lookup_data[out_lsb(n, OUT_BITS) +: OUT_BITS])
`ifdef LUT_NEURON_READBACK_EN
      ,
      .cfg_raddr(cfg_addr),
      .cfg_rdata(cfg_rd_all[out_lsb(n, OUT_BITS) +: OUT_BITS])
`endif
    );
  end

  // Pipeline next state: each stage loads whenever the stage after it can move.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_addr_d = in_data;
      end
    end
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = lookup_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

`ifdef LUT_NEURON_READBACK_EN
  logic                cfg_rvalid_q, cfg_rvalid_d;
  logic [OUT_BITS-1:0] cfg_rdata_q,  cfg_rdata_d;

  // Readback: selected entry, or zero for an out-of-range neuron.
  always_comb begin
    cfg_rvalid_d = cfg_re;
    cfg_rdata_d  = cfg_rdata_q;
    if (cfg_re) begin
      cfg_rdata_d = '0;
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
        if (cfg_neuron == NEUR_IDX_W'(n)) begin
          cfg_rdata_d = cfg_rd_all[n*OUT_BITS +: OUT_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= '0;
    end else begin
      cfg_rvalid_q <= cfg_rvalid_d;
      cfg_rdata_q  <= cfg_rdata_d;
    end
  end

  assign cfg_rvalid = cfg_rvalid_q;
  assign cfg_rdata  = cfg_rdata_q;
`endif

endmodule
